// File: rtl/decode_queue_if.sv
// Handshake/payload bundle between fetch, the decode queue and decode.
// The queue uses the slave modport; the driver side uses master.
interface decode_queue_if #(
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = 32
);
  localparam int COUNT_WIDTH = $clog2(DEPTH) + 1;

  // fetch side
  logic                   valid_in;
  logic                   ready_out;
  logic [PC_WIDTH-1:0]    pc_in;
  logic [PC_WIDTH-1:0]    next_pc_in;
  logic [31:0]            instruction_in;
  logic                   invalidate;

  // decode side
  logic                   valid_out;
  logic                   ready_in;
  logic [PC_WIDTH-1:0]    pc_out;
  logic [PC_WIDTH-1:0]    next_pc_out;
  logic [31:0]            instruction_out;
  logic [4:0]             rd_address_out;
  logic [4:0]             rs1_address_out;
  logic [4:0]             rs2_address_out;
  logic [3:0]             class_out;
  logic [31:0]            imm_data_out;
  logic                   illegal_out;
  logic [COUNT_WIDTH-1:0] count_out;

  modport slave (
    input  valid_in, pc_in, next_pc_in, instruction_in, invalidate, ready_in,
    output ready_out, valid_out, pc_out, next_pc_out, instruction_out,
           rd_address_out, rs1_address_out, rs2_address_out,
           class_out, imm_data_out, illegal_out, count_out
  );

  modport master (
    output valid_in, pc_in, next_pc_in, instruction_in, invalidate, ready_in,
    input  ready_out, valid_out, pc_out, next_pc_out, instruction_out,
           rd_address_out, rs1_address_out, rs2_address_out,
           class_out, imm_data_out, illegal_out, count_out
  );
endinterface

// File: rtl/decode_queue.sv
// DEPTH-entry instruction FIFO between fetch and decode; each instruction is
// predecoded (class, immediate, illegal) on enqueue and stored with its entry.
module decode_queue #(
  parameter int DEPTH     = 4,
  parameter int PC_WIDTH  = 32,
  parameter int PREDECODE = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  decode_queue_if.slave q
);

  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam int CNT_WIDTH = PTR_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(DEPTH);

  typedef enum logic [3:0] {
    CLS_LUI     = 4'd0,
    CLS_AUIPC   = 4'd1,
    CLS_JAL     = 4'd2,
    CLS_JALR    = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_LOAD    = 4'd5,
    CLS_STORE   = 4'd6,
    CLS_OP_IMM  = 4'd7,
    CLS_OP      = 4'd8,
    CLS_FENCE   = 4'd9,
    CLS_SYSTEM  = 4'd10,
    CLS_ILLEGAL = 4'd15
  } op_class_e;

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] next_pc;
    logic [31:0]         instr;
    op_class_e           op_class;
    logic [31:0]         imm;
    logic                illegal;
  } entry_t;

  entry_t                mem [DEPTH];
  logic [PTR_WIDTH-1:0]  head;
  logic [PTR_WIDTH-1:0]  tail;
  logic [CNT_WIDTH-1:0]  count;
  entry_t                wr_entry;
  entry_t                rd_entry;
  logic                  push;
  logic                  pop;

  // Handshake status comes only from registered count, so ready_out never
  // depends combinationally on ready_in and an empty queue never bypasses.
  assign q.ready_out = (count != FULL_COUNT);
  assign q.valid_out = (count != '0);
  assign push        = q.valid_in && q.ready_out && !q.invalidate;
  assign pop         = q.valid_out && q.ready_in && !q.invalidate;

  // Predecode of the incoming instruction.
  logic [31:0] instr;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign instr = q.instruction_in;
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_entry         = '0;
    wr_entry.pc      = q.pc_in;
    wr_entry.next_pc = q.next_pc_in;
    wr_entry.instr   = instr;
    if (PREDECODE != 0) begin
      unique case (instr[6:0])
        7'b0110111: begin wr_entry.op_class = CLS_LUI;    wr_entry.imm = imm_u; end
        7'b0010111: begin wr_entry.op_class = CLS_AUIPC;  wr_entry.imm = imm_u; end
        7'b1101111: begin wr_entry.op_class = CLS_JAL;    wr_entry.imm = imm_j; end
        7'b1100111: begin wr_entry.op_class = CLS_JALR;   wr_entry.imm = imm_i; end
        7'b1100011: begin wr_entry.op_class = CLS_BRANCH; wr_entry.imm = imm_b; end
        7'b0000011: begin wr_entry.op_class = CLS_LOAD;   wr_entry.imm = imm_i; end
        7'b0100011: begin wr_entry.op_class = CLS_STORE;  wr_entry.imm = imm_s; end
        7'b0010011: begin wr_entry.op_class = CLS_OP_IMM; wr_entry.imm = imm_i; end
        7'b0110011: wr_entry.op_class = CLS_OP;
        7'b0001111: wr_entry.op_class = CLS_FENCE;
        7'b1110011: begin
          wr_entry.op_class = CLS_SYSTEM;
          // CSR immediate forms carry a 5-bit zero-extended uimm in rs1.
          wr_entry.imm      = instr[14] ? {27'b0, instr[19:15]} : imm_i;
        end
        default: begin
          wr_entry.op_class = CLS_ILLEGAL;
          wr_entry.illegal  = 1'b1;
        end
      endcase
    end
  end

  // NOTE: the entry array has no reset; valid_out gates every read, so stale
  // contents are never visible and the storage stays plain flops/RAM.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= wr_entry;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (q.invalidate) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_comb begin
    rd_entry = '0;
    if (q.valid_out) rd_entry = mem[head];
  end

  assign q.pc_out          = rd_entry.pc;
  assign q.next_pc_out     = rd_entry.next_pc;
  assign q.instruction_out = rd_entry.instr;
  assign q.rd_address_out  = rd_entry.instr[11:7];
  assign q.rs1_address_out = rd_entry.instr[19:15];
  assign q.rs2_address_out = rd_entry.instr[24:20];
  assign q.class_out       = rd_entry.op_class;
  assign q.imm_data_out    = rd_entry.imm;
  assign q.illegal_out     = rd_entry.illegal;
  assign q.count_out       = count;

endmodule
